// File: rtl/fir_in_buffer.sv
// fir_in_buffer
//   Captures one sample from the switch inputs on each rising edge of the
//   capture strobe. The samples are queued in a small FIFO and presented to
//   the FIR stage through an AXI-Stream style valid/ready handshake.
//
//   Optional build macro: FIR_IN_SYNC_EN
//     When this macro is defined, an extra register stage is placed on
//     pin_strobe and pin_data. Together with the input stage it forms a
//     two-flop synchronizer, and it adds one cycle of latency.
//
//   Parameters
//     DATA_W  sample width
//     DEPTH   FIFO entries. Must be a power of two and at least 2.
//
//   Ports
//     clk            sole clock; all state updates on the rising edge
//     reset          synchronous, active-high reset
//     pin_data       raw sample from the switches
//     pin_strobe     raw capture strobe; each rising edge requests one sample
//     m_axis_tdata   head sample
//     m_axis_tvalid  head sample valid (FIFO not empty)
//     m_axis_tready  downstream accepts the head sample
//     fill           current entry count, 0..DEPTH
//     overflow       sticky; set when a capture is dropped because the FIFO is full
module fir_in_buffer #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        pin_data,
  input  logic                     pin_strobe,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  // Optional synchronizer stage
  logic              stage_strobe;
  logic [DATA_W-1:0] stage_data;

`ifdef FIR_IN_SYNC_EN
  logic              sync_strobe_reg;
  logic [DATA_W-1:0] sync_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_strobe_reg <= 1'b0;
      sync_data_reg   <= '0;
    end else begin
      sync_strobe_reg <= pin_strobe;
      sync_data_reg   <= pin_data;
    end
  end

  assign stage_strobe = sync_strobe_reg;
  assign stage_data   = sync_data_reg;
`else
  assign stage_strobe = pin_strobe;
  assign stage_data   = pin_data;
`endif

  // Input stage and edge detector
  logic              s_strobe_reg;
  logic              s_strobe_d_reg;
  logic [DATA_W-1:0] s_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_strobe_reg   <= 1'b0;
      s_strobe_d_reg <= 1'b0;
      s_data_reg     <= '0;
    end else begin
      s_strobe_reg   <= stage_strobe;
      s_strobe_d_reg <= s_strobe_reg;
      s_data_reg     <= stage_data;
    end
  end

  // s_strobe_d clears on reset. A strobe that is already high at reset
  // release therefore shows up as a fresh rising edge.
  logic capture;
  assign capture = s_strobe_reg & ~s_strobe_d_reg;

  // FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic              overflow_reg, overflow_next;

  logic full;
  logic pop;
  logic push_ok;

  assign full = (fill_reg == FILL_W'(DEPTH));
  assign pop  = (fill_reg != '0) && m_axis_tready;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // still succeeds.
  assign push_ok = capture && (!full || pop);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fill_next     = fill_reg;
    overflow_next = overflow_reg;
    // The pointers are PTR_W bits wide and DEPTH is a power of two,
    // so incrementing them wraps naturally modulo DEPTH.
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)     rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push_ok, pop})
      2'b10:   fill_next = fill_reg + 1'b1;
      2'b01:   fill_next = fill_reg - 1'b1;
      default: fill_next = fill_reg;
    endcase
    if (capture && !push_ok) overflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fill_reg     <= fill_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is not reset. A capture that is pending while reset is
  // asserted is discarded.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr_reg] <= s_data_reg;
  end

  // The head is masked while the FIFO is empty. This keeps tdata at 0
  // after reset even though the storage itself is not cleared.
  assign m_axis_tvalid = (fill_reg != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr_reg] : '0;
  assign fill          = fill_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_fir_in_buffer.sv
module tb_fir_in_buffer;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 4;
`ifdef FIR_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] pin_data;
  logic              pin_strobe;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [2:0]        fill;
  logic              overflow;

  fir_in_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pin_data(pin_data), .pin_strobe(pin_strobe),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .fill(fill), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [DATA_W-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compares each accepted beat against the scoreboard, and checks
  // that tdata stays stable while the output is stalled.
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] held_data  = '0;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && m_axis_tvalid) check("stall_stable", m_axis_tdata, held_data);
      if (fill > 3'(DEPTH)) check("fill_bound", fill, DEPTH);
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
        end else begin
          check("beat", m_axis_tdata, sb.pop_front());
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held_data  = m_axis_tdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DATA_W-1:0] d, input bit accepted);
    pin_data   = d;
    pin_strobe = 1'b1;
    if (accepted) sb.push_back(d);
    tick();
    pin_strobe = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_fill0"}, fill, 0);
    check({name, "_tvalid0"}, m_axis_tvalid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    sb.delete();
    reset = 1'b0;
  endtask

  int b0;

  initial begin
    reset = 1'b1; pin_data = '0; pin_strobe = 1'b0; m_axis_tready = 1'b0;
    tick(); tick();
    check("rst_fill", fill, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tdata", m_axis_tdata, 0);
    reset = 1'b0;
    tick();

    // Single beat, strobe held high, latency check
    m_axis_tready = 1'b1;
    b0 = beats;
    pin_data = 6'h2A; pin_strobe = 1'b1; sb.push_back(6'h2A);
    repeat (LAT - 1) tick();
    check("lat_before", m_axis_tvalid, 0);
    tick();
    check("lat_at", m_axis_tvalid, 1);
    check("lat_data", m_axis_tdata, 6'h2A);
    repeat (5 - LAT) tick();
    pin_strobe = 1'b0;
    repeat (4) tick();
    check("single_beats", beats - b0, 1);
    check("single_fill0", fill, 0);

    // Four samples queued with tready low, then released back to back
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(6'(i), 1'b1);
    repeat (LAT) tick();
    check("q4_fill", fill, 4);
    check("q4_overflow", overflow, 0);
    b0 = beats;
    m_axis_tready = 1'b1;
    repeat (4) tick();
    check("q4_beats", beats - b0, 4);
    check("q4_tvalid0", m_axis_tvalid, 0);
    check("q4_sb_empty", sb.size(), 0);

    // Overflow: a fifth sample is dropped
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(6'(i), 1'b1);
    pulse(6'd5, 1'b0);
    repeat (LAT) tick();
    check("ovf_flag", overflow, 1);
    check("ovf_fill", fill, 4);
    drain("ovf_drain");
    repeat (3) tick();
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);

    // Push into a full FIFO on the same edge as a pop
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(6'(i), 1'b1);
    repeat (LAT) tick();
    pin_data = 6'd9; pin_strobe = 1'b1; sb.push_back(6'd9);
    repeat (LAT - 1) tick();
    m_axis_tready = 1'b1;
    pin_strobe = 1'b0;
    tick();
    m_axis_tready = 1'b0;
    check("pp_fill", fill, 4);
    check("pp_overflow", overflow, 0);
    check("pp_head", m_axis_tdata, 2);
    drain("pp_drain");

    // Reset arriving on the same edge as a pending capture
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 3; i++) pulse(6'(i + 16), 1'b1);
    repeat (LAT) tick();
    pin_data = 6'd7; pin_strobe = 1'b1;
    repeat (LAT - 1) tick();
    reset = 1'b1; pin_strobe = 1'b0;
    tick();
    sb.delete();
    reset = 1'b0;
    check("rp_fill", fill, 0);
    check("rp_tvalid", m_axis_tvalid, 0);
    check("rp_overflow", overflow, 0);
    check("rp_tdata", m_axis_tdata, 0);
    m_axis_tready = 1'b1;
    b0 = beats;
    repeat (6) tick();
    check("rp_no_beat", beats - b0, 0);

    // A strobe already high when reset is released counts as a rising edge
    reset = 1'b1; pin_data = 6'h15; pin_strobe = 1'b1;
    tick(); tick();
    sb.delete();
    reset = 1'b0;
    sb.push_back(6'h15);
    b0 = beats;
    repeat (LAT + 4) tick();
    pin_strobe = 1'b0;
    repeat (3) tick();
    check("rel_beats", beats - b0, 1);
    check("rel_sb_empty", sb.size(), 0);

    // Random strobe and tready traffic. New captures are only issued while
    // the scoreboard holds fewer than DEPTH entries, so no capture is dropped.
    for (int c = 0; c < 10000; c++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      pin_data = 6'($urandom);
      if (pin_strobe) begin
        if ($urandom_range(0, 2) == 0) pin_strobe = 1'b0;
      end else if (sb.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        pin_strobe = 1'b1;
        sb.push_back(pin_data);
      end
      tick();
    end
    pin_strobe = 1'b0;
    repeat (LAT) tick();
    drain("rnd_drain");
    check("rnd_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_in_buffer.md
FIR_IN_BUFFER -- requirements
Module: fir_in_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 6, sample width matching the FIR input.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; only powers of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pin_data  input  DATA_W  raw sample from the input switches.
REQ-006 SHALL have port pin_strobe  input  1  raw capture strobe from the switches; a rising edge requests one sample.
REQ-007 SHALL have port m_axis_tdata  output  DATA_W  sample to the FIR stage.
REQ-008 SHALL have port m_axis_tvalid  output  1  head sample valid.
REQ-009 SHALL have port m_axis_tready  input  1  FIR stage accepts the head sample.
REQ-010 SHALL have port fill  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-012 SHALL register pin_strobe and pin_data every cycle into an input stage (s_strobe, s_data); a second register, s_strobe_d, SHALL hold the previous s_strobe.
REQ-013 SHALL detect capture as s_strobe=1 and s_strobe_d=0; a strobe held high for any number of cycles SHALL produce exactly one capture.
REQ-014 SHALL write s_data into the FIFO on the clock edge after capture is detected (push); pin-high-to-tvalid latency is 2 cycles with an empty FIFO and without REQ-026.
REQ-015 SHALL drive m_axis_tvalid = (fill != 0) and m_axis_tdata = FIFO head, both from registered state with no combinational path from pin_* to the outputs.
REQ-016 SHALL pop the head on every edge where m_axis_tvalid=1 and m_axis_tready=1.
REQ-017 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-018 SHALL deliver samples in capture order (FIFO), with read and write pointers wrapping modulo DEPTH.
REQ-019 Push with fill<DEPTH SHALL store the sample; fill SHALL be +1, -1 or unchanged for push-only, pop-only or push+pop.
REQ-020 Push with fill=DEPTH and a pop on the same edge SHALL be accepted; fill stays DEPTH.
REQ-021 Push with fill=DEPTH and no pop SHALL drop the sample, leave FIFO contents unchanged, and set overflow.
REQ-022 overflow SHALL remain 1 until reset; no other event clears it.
REQ-023 m_axis_tready while m_axis_tvalid=0 SHALL have no effect.

Reset
REQ-024 While reset=1 on an edge: fill=0, pointers=0, m_axis_tvalid=0, overflow=0, s_strobe=s_strobe_d=0, s_data=0, with m_axis_tdata=0 after reset; a push pending on that edge SHALL be discarded.
REQ-025 The first edge with reset=0 SHALL sample pins normally; a strobe already high at reset release SHALL count as a rising edge and capture one sample.

Configuration
REQ-026 With macro FIR_IN_SYNC_EN defined, pin_strobe and pin_data SHALL pass through one extra register stage (two-flop synchronizer) before the REQ-012 stage, reset to 0, adding 1 cycle latency (3 total); without it the stage SHALL be absent and latency is 2.

Verification
REQ-027 Reset, pin_data=6'h2A, strobe 0->1 held 5 cycles, tready=1 -> exactly one beat 6'h2A, tvalid high 2 cycles after strobe rise (3 with FIR_IN_SYNC_EN), fill returns 0.
REQ-028 tready=0, four strobe pulses with data 1,2,3,4 -> fill=4, overflow=0; raise tready -> beats 1,2,3,4 in order on consecutive cycles, then tvalid=0.
REQ-029 FIFO full (1..4), tready=0, fifth pulse data 5 -> overflow=1, fill=4; drain -> 1,2,3,4 only; overflow stays 1 until reset.
REQ-030 FIFO full, tready=1 on the same edge a push of data 9 occurs -> pop of 1 and store of 9, fill=4, overflow=0; drain -> 2,3,4,9.
REQ-031 Pending capture and reset=1 asserted on the same edge, 3 samples queued -> fill=0, tvalid=0, overflow=0; no sample emerges after release unless strobe is still high (REQ-025).
REQ-032 Random strobe/tready stimulus over 10000 cycles with DEPTH=4 -> scoreboard matches output order, fill never exceeds 4, tdata stable during stall.
